// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the burst master and the memory-slave blocks:
// burst/response encodings, fixed size/cache values, master FSM state type.
package axi4_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } mst_state_e;

  // A 4-byte-beat INCR burst starting at word index word_idx (addr[11:2])
  // with len+1 beats runs past the 4 KB page when the last word index > 1023.
  function automatic logic crosses_4k(input logic [9:0] word_idx, input logic [7:0] len);
    return ({1'b0, word_idx} + {3'b000, len}) > 11'd1023;
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// AXI4-full initiator: one local command (addr, len, write) becomes one INCR
// burst of 32-bit beats. One transaction outstanding at a time.
//   cmd_*            : command handshake (cmd_ready only in IDLE)
//   wr_data/valid/ready : write-data stream, passed through to W
//   rd_data/valid/last/ready : read-data stream, passed through from R
//   done / error     : one-cycle completion pulse / status of last transaction
//   M_AXI_*          : AXI4 master interface (AW, W, B, AR, R)
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int TRANSACTION_ID     = 0,
  parameter int MAX_BURST_LEN      = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                      cmd_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_valid,
  output logic                            rd_last,
  input  logic                            rd_ready,
  output logic                            done,
  output logic                            error,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic [3:0]                      M_AXI_AWREGION,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [3:0]                      M_AXI_ARREGION,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [C_M_AXI_ID_WIDTH-1:0]   TID       = C_M_AXI_ID_WIDTH'(TRANSACTION_ID);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] WORD_MASK = ~C_M_AXI_ADDR_WIDTH'(3);

  mst_state_e                    state_q;
  logic [7:0]                    len_q;
  logic [7:0]                    beat_q;
  logic                          err_q;
  logic                          awvalid_q;
  logic                          arvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                    awlen_q;
  logic [7:0]                    arlen_q;

  logic last_beat;
  logic cmd_bad;
  logic w_hs;
  logic r_hs;

  assign last_beat = (beat_q == len_q);
  assign cmd_bad   = (32'(cmd_len) >= 32'(MAX_BURST_LEN)) || crosses_4k(cmd_addr[11:2], cmd_len);
  assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
  assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      awlen_q   <= '0;
      arlen_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q  <= cmd_len;
            beat_q <= '0;
            err_q  <= 1'b0;
            if (cmd_bad) begin
              // Rejected commands complete immediately with no bus traffic.
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (cmd_write) begin
              awaddr_q  <= cmd_addr & WORD_MASK;
              awlen_q   <= cmd_len;
              awvalid_q <= 1'b1;
              state_q   <= ST_WR_ADDR;
            end else begin
              araddr_q  <= cmd_addr & WORD_MASK;
              arlen_q   <= cmd_len;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_ADDR: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            state_q   <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            err_q   <= (M_AXI_BRESP != AXI_RESP_OKAY) || (M_AXI_BID != TID);
            state_q <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            beat_q <= beat_q + 8'd1;
            // Error is sticky for the rest of the burst; RLAST must coincide
            // exactly with the final expected beat.
            if ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RID != TID) ||
                (M_AXI_RLAST != last_beat))
              err_q <= 1'b1;
            if (M_AXI_RLAST || last_beat) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = err_q;

  assign M_AXI_AWID     = TID;
  assign M_AXI_AWADDR   = awaddr_q;
  assign M_AXI_AWLEN    = awlen_q;
  assign M_AXI_AWSIZE   = AXI_SIZE_4B;
  assign M_AXI_AWBURST  = AXI_BURST_INCR;
  assign M_AXI_AWLOCK   = 1'b0;
  assign M_AXI_AWCACHE  = AXI_CACHE_DEFAULT;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWQOS    = '0;
  assign M_AXI_AWREGION = '0;
  assign M_AXI_AWVALID  = awvalid_q;

  assign M_AXI_WDATA  = wr_data;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WVALID = (state_q == ST_WR_DATA) && wr_valid;
  assign M_AXI_WLAST  = (state_q == ST_WR_DATA) && last_beat;
  assign wr_ready     = (state_q == ST_WR_DATA) && M_AXI_WREADY;

  assign M_AXI_BREADY = (state_q == ST_WR_RESP);

  assign M_AXI_ARID     = TID;
  assign M_AXI_ARADDR   = araddr_q;
  assign M_AXI_ARLEN    = arlen_q;
  assign M_AXI_ARSIZE   = AXI_SIZE_4B;
  assign M_AXI_ARBURST  = AXI_BURST_INCR;
  assign M_AXI_ARLOCK   = 1'b0;
  assign M_AXI_ARCACHE  = AXI_CACHE_DEFAULT;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARQOS    = '0;
  assign M_AXI_ARREGION = '0;
  assign M_AXI_ARVALID  = arvalid_q;

  assign M_AXI_RREADY = (state_q == ST_RD_DATA) && rd_ready;
  assign rd_valid     = (state_q == ST_RD_DATA) && M_AXI_RVALID;
  assign rd_last      = (state_q == ST_RD_DATA) && M_AXI_RLAST;
  assign rd_data      = M_AXI_RDATA;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: 64-byte AXI4 slave model, stimulus tasks that
// queue expected AW/AR/W/read-beat/done results, and a monitor that pops and
// compares them whenever the DUT presents a handshake or a done pulse.
module tb_axi4_burst_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic        done, error;
  logic [0:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  axi4_burst_master #(
    .C_M_AXI_ID_WIDTH  (1),
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(32),
    .TRANSACTION_ID    (0),
    .MAX_BURST_LEN     (16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .error(error),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWREGION(awregion),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic last; } bt_t;

  ax_t  exp_aw[$];
  ax_t  exp_ar[$];
  bt_t  exp_w[$];
  bt_t  exp_rd[$];
  logic exp_done[$];

  // slave model knobs
  logic [1:0]  bresp_cfg  = 2'b00;
  logic        early_en   = 1'b0;
  logic [3:0]  early_beat = 4'd0;
  logic [31:0] mem [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push_ax(input logic wr, input logic [31:0] a, input logic [7:0] l);
    ax_t e;
    e.addr = a;
    e.len  = l;
    if (wr) exp_aw.push_back(e);
    else    exp_ar.push_back(e);
  endfunction

  function automatic void push_bt(input logic wr, input logic [31:0] d, input logic last);
    bt_t b;
    b.data = d;
    b.last = last;
    if (wr) exp_w.push_back(b);
    else    exp_rd.push_back(b);
  endfunction

  // Slave: inputs driven on negedge; handshakes observed 1 time unit later,
  // i.e. before the posedge that completes them.
  initial begin : slave
    logic       aw_wait, ar_wait, b_pend, r_act;
    logic [3:0] w_base, w_beat, r_base, r_beat;
    logic [7:0] r_len;
    aw_wait = 0; ar_wait = 0; b_pend = 0; r_act = 0;
    w_base = 0; w_beat = 0; r_base = 0; r_beat = 0; r_len = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + 32'(i);
    awready = 0; arready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    forever begin
      @(negedge clk);
      awready = aw_wait;
      arready = ar_wait;
      wready  = 1'b1;
      bvalid  = b_pend;
      bresp   = b_pend ? bresp_cfg : 2'b00;
      rvalid  = r_act;
      rdata   = r_act ? mem[r_base + r_beat] : 32'h0;
      rlast   = r_act && ((8'(r_beat) == r_len) || (early_en && r_beat == early_beat));
      #1;
      if (rst) begin
        aw_wait = 0; ar_wait = 0; b_pend = 0; r_act = 0;
      end else begin
        if (awvalid && awready) begin aw_wait = 0; w_base = awaddr[5:2]; w_beat = 0; end
        else if (awvalid) aw_wait = 1;
        if (bvalid && bready) b_pend = 0;
        if (wvalid && wready) begin
          mem[w_base + w_beat] = wdata;
          w_beat++;
          if (wlast) b_pend = 1;
        end
        if (arvalid && arready) begin
          ar_wait = 0; r_base = araddr[5:2]; r_len = arlen; r_beat = 0; r_act = 1;
        end else if (arvalid) ar_wait = 1;
        if (rvalid && rready) begin
          if (rlast) r_act = 0;
          r_beat++;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    ax_t  a;
    bt_t  b;
    logic e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (awvalid && awready) begin
          chk("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) begin
            a = exp_aw.pop_front();
            chk("awaddr", awaddr, a.addr);
            chk("awlen", awlen, a.len);
            chk("awsize_burst", {awsize, awburst, awcache}, {3'b010, 2'b01, 4'b0011});
          end
        end
        if (wvalid && wready) begin
          chk("w_expected", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) begin
            b = exp_w.pop_front();
            chk("wdata", wdata, b.data);
            chk("wlast", wlast, b.last);
            chk("wstrb", wstrb, 4'hF);
          end
        end
        if (arvalid && arready) begin
          chk("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            a = exp_ar.pop_front();
            chk("araddr", araddr, a.addr);
            chk("arlen", arlen, a.len);
          end
        end
        if (rd_valid && rd_ready) begin
          chk("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) begin
            b = exp_rd.pop_front();
            chk("rd_data", rd_data, b.data);
            chk("rd_last", rd_last, b.last);
          end
        end
        if (done) begin
          chk("done_expected", exp_done.size() != 0, 1);
          if (exp_done.size() != 0) begin
            e = exp_done.pop_front();
            chk("done_error", error, e);
          end
        end
      end
    end
  end

  // Returns at the negedge after the accepting posedge.
  task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l);
    int unsigned t = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    #1;
    while (!cmd_ready && t < 50) begin @(negedge clk); #1; t++; end
    chk("cmd_accept_timeout", t < 50, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  // Called at a negedge; polls done after each edge.
  task automatic wait_done(input logic toggle_rd);
    int unsigned t = 0;
    rd_ready = toggle_rd ? 1'b0 : 1'b1;
    #1;
    while (!done && t < 300) begin
      @(negedge clk);
      if (toggle_rd) rd_ready = ~rd_ready;
      #1;
      t++;
    end
    chk("done_timeout", t < 300, 1);
    @(negedge clk);
    rd_ready = 0;
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] l, input logic [31:0] base,
                             input int unsigned gap_beat, input int unsigned gap_n,
                             input int unsigned abort_beat, input logic exp_err);
    int unsigned beat = 0, gaps = 0, t = 0;
    push_ax(1, a, l);
    for (int unsigned i = 0; i <= 32'(l); i++)
      if (i < abort_beat) push_bt(1, base + i, i == 32'(l));
    if (abort_beat > 32'(l)) exp_done.push_back(exp_err);
    issue_cmd(1, a, l);
    #1;
    chk("err_clear_on_accept", error, 0);
    while (beat <= 32'(l) && t < 300) begin
      @(negedge clk);
      t++;
      if (beat == abort_beat) begin
        rst = 1; wr_valid = 1; wr_data = base + beat;
        return;
      end
      if (beat == gap_beat && gaps < gap_n) begin
        wr_valid = 0;
        gaps++;
        #1;
        chk("gap_wvalid", wvalid, 0);
        chk("gap_wlast", wlast, 0);
      end else begin
        wr_valid = 1; wr_data = base + beat;
        #1;
        if (wr_ready) beat++;
      end
    end
    chk("wr_feed_timeout", t < 300, 1);
    @(negedge clk);
    wr_valid = 0;
    wait_done(0);
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [31:0] exp_a, input logic [7:0] l,
                            input logic toggle, input logic exp_err);
    push_ax(0, exp_a, l);
    exp_done.push_back(exp_err);
    issue_cmd(0, a, l);
    wait_done(toggle);
  endtask

  task automatic bad_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l);
    exp_done.push_back(1'b1);
    issue_cmd(wr, a, l);
    wait_done(0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] m [16];
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_valid = 1; rd_ready = 1; rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done_err", {done, error, rd_valid, rd_last}, 4'b0000);
    chk("rst_payload", {awaddr, awlen, araddr, arlen}, 80'h0);
    @(negedge clk);
    rst = 0; wr_valid = 0; rd_ready = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    // basic write and read-back with rd_ready stalls
    write_burst(32'h10, 8'd3, 32'hA0, 99, 0, 99, 0);
    push_bt(0, 32'hA0, 0); push_bt(0, 32'hA1, 0); push_bt(0, 32'hA2, 0); push_bt(0, 32'hA3, 1);
    read_burst(32'h10, 32'h10, 8'd3, 1, 0);

    // wr_valid gap of 5 cycles at beat 1
    write_burst(32'h20, 8'd3, 32'hB0, 1, 5, 99, 0);

    // SLVERR on B; error held in IDLE, cleared when the next command is taken
    bresp_cfg = 2'b10;
    write_burst(32'h30, 8'd0, 32'hC0, 99, 0, 99, 1);
    bresp_cfg = 2'b00;
    #1;
    chk("err_held_idle", error, 1);
    write_burst(32'h34, 8'd0, 32'hC1, 99, 0, 99, 0);

    // early RLAST on third beat of a 4-beat read
    early_en = 1; early_beat = 4'd2;
    push_bt(0, 32'hA0, 0); push_bt(0, 32'hA1, 0); push_bt(0, 32'hA2, 1);
    read_burst(32'h10, 32'h10, 8'd3, 0, 1);
    early_en = 0;
    #1;
    chk("idle_after_early_rlast", cmd_ready, 1);

    // rejected commands: len too long, 4 KB crossing
    bad_cmd(1, 32'h0, 8'd16);
    bad_cmd(0, 32'hFF8, 8'd3);

    // legal up to the page end, unaligned start address
    push_bt(0, 32'hC0, 0); push_bt(0, 32'hC1, 0); push_bt(0, 32'h100E, 0); push_bt(0, 32'h100F, 1);
    read_burst(32'hFF3, 32'hFF0, 8'd3, 0, 0);

    // maximum legal length: whole 64-byte slave memory
    for (int i = 0; i < 16; i++) m[i] = 32'h1000 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      m[4 + i] = 32'hA0 + 32'(i);
      m[8 + i] = 32'hB0 + 32'(i);
    end
    m[12] = 32'hC0; m[13] = 32'hC1;
    for (int i = 0; i < 16; i++) push_bt(0, m[i], i == 15);
    read_burst(32'h0, 32'h0, 8'd15, 1, 0);

    // reset during beat 2 of a write, then a normal single-beat write
    write_burst(32'h0, 8'd3, 32'hD0, 99, 0, 2, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    wr_valid = 0;
    write_burst(32'h4, 8'd0, 32'hE0, 99, 0, 99, 0);

    repeat (3) @(negedge clk);
    chk("aw_q_empty", exp_aw.size(), 0);
    chk("w_q_empty", exp_w.size(), 0);
    chk("ar_q_empty", exp_ar.size(), 0);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("done_q_empty", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
